vai_tx_sched: RTL and testbench

VAI_TX_SCHED -- requirements
Module: vai_tx_sched

---
 rtl/vai_tx_sched_pkg.sv | 16 +
 rtl/vai_tx_sched_if.sv | 23 ++
 rtl/vai_rr_pick.sv | 30 +++
 rtl/vai_tx_sched.sv | 134 +++++++++++++
 tb/tb_vai_tx_sched.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vai_tx_sched_pkg.sv
// Shared definitions for the VAI Tx scheduler: FSM state type and width defaults.
package vai_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RUN    = 2'd2
  } t_vai_sched_state;

  localparam int unsigned DEF_EPOCH_W = 16;
  localparam int unsigned DEF_QUOTA_W = 8;

  // A quota of all-ones means the AFU is never token-limited.
  localparam logic [DEF_QUOTA_W-1:0] QUOTA_UNLIMITED = '1;

endpackage

// File: rtl/vai_tx_sched_if.sv
// Request/grant and upstream Tx bundle between sub-AFUs, the scheduler and upstream.
interface vai_tx_sched_if #(
  parameter int unsigned NUM_SUB_AFUS = 15,
  parameter int unsigned DW           = 64
);
  logic [NUM_SUB_AFUS-1:0]               req_valid;
  logic [NUM_SUB_AFUS-1:0][DW-1:0]       req_data;
  logic [NUM_SUB_AFUS-1:0]               req_ready;
  logic                                  out_valid;
  logic [DW-1:0]                         out_data;
  logic [$clog2(NUM_SUB_AFUS)-1:0]       out_src;
  logic                                  out_almfull;

  modport slave (
    input  req_valid, req_data, out_almfull,
    output req_ready, out_valid, out_data, out_src
  );

  modport master (
    output req_valid, req_data, out_almfull,
    input  req_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/vai_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module vai_rr_pick #(
  parameter int unsigned N = 15
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_any
);
  localparam int unsigned SRC_W = $clog2(N);

  int unsigned j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) j = j - N;
      if (!grant_any && eligible[j]) begin
        grant[j]  = 1'b1;
        grant_idx = SRC_W'(j);
        grant_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vai_tx_sched.sv
// Epoch/token-quota round-robin scheduler merging sub-AFU requests onto one Tx path.
// Optional per-AFU transfer statistics when VAI_TX_SCHED_STATS_EN is defined.
module vai_tx_sched
  import vai_sched_pkg::*;
#(
  parameter int unsigned NUM_SUB_AFUS = 15,
  parameter int unsigned DW           = 64,
  parameter int unsigned EPOCH_W      = DEF_EPOCH_W,
  parameter int unsigned QUOTA_W      = DEF_QUOTA_W
) (
  input  logic                            pClk,
  input  logic                            SoftReset_n,
  vai_tx_sched_if.slave                   bus,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_SUB_AFUS)-1:0] cfg_idx,
  input  logic [QUOTA_W-1:0]              cfg_quota,
  input  logic [EPOCH_W-1:0]              cfg_epoch,
  input  logic                            cfg_enable
`ifdef VAI_TX_SCHED_STATS_EN
  ,
  input  logic [$clog2(NUM_SUB_AFUS)-1:0] stat_idx,
  output logic [31:0]                     stat_cnt
`endif
);
  localparam int unsigned SRC_W = $clog2(NUM_SUB_AFUS);

  t_vai_sched_state        state;
  logic [SRC_W-1:0]        rr_ptr;
  logic [EPOCH_W-1:0]      epoch_cnt;
  logic [QUOTA_W-1:0]      tokens [NUM_SUB_AFUS];
  logic [QUOTA_W-1:0]      quota  [NUM_SUB_AFUS];

  logic [NUM_SUB_AFUS-1:0] eligible;
  logic [NUM_SUB_AFUS-1:0] grant;
  logic [SRC_W-1:0]        grant_idx;
  logic                    grant_any;
  logic                    cfg_idx_ok;

  // Index ports that can encode values beyond the last AFU need a range check.
  if ((2 ** SRC_W) == NUM_SUB_AFUS) begin : g_idx_full
    assign cfg_idx_ok = 1'b1;
  end else begin : g_idx_part
    assign cfg_idx_ok = (cfg_idx < SRC_W'(NUM_SUB_AFUS));
  end

  always_comb begin
    eligible = '0;
    if (state == ST_RUN && !bus.out_almfull) begin
      for (int unsigned i = 0; i < NUM_SUB_AFUS; i++) begin
        eligible[i] = bus.req_valid[i] & ((tokens[i] != '0) | (quota[i] == '1));
      end
    end
  end

  vai_rr_pick #(
    .N(NUM_SUB_AFUS)
  ) u_pick (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // eligible already folds in req_valid, so any grant bit is a transfer.
  assign bus.req_ready = grant;

  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      epoch_cnt     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      for (int unsigned i = 0; i < NUM_SUB_AFUS; i++) begin
        tokens[i] <= '0;
        quota[i]  <= '1;
      end
    end else begin
      bus.out_valid <= grant_any;
      if (grant_any) begin
        bus.out_data <= bus.req_data[grant_idx];
        bus.out_src  <= grant_idx;
        rr_ptr       <= (grant_idx == SRC_W'(NUM_SUB_AFUS - 1)) ? '0 : grant_idx + 1'b1;
        if (quota[grant_idx] != '1 && tokens[grant_idx] != '0)
          tokens[grant_idx] <= tokens[grant_idx] - 1'b1;
      end

      // REFILL overrides the grant's token decrement and samples quota before any same-cycle write.
      unique case (state)
        ST_IDLE: begin
          if (cfg_enable) state <= ST_REFILL;
        end
        ST_REFILL: begin
          for (int unsigned i = 0; i < NUM_SUB_AFUS; i++) tokens[i] <= quota[i];
          epoch_cnt <= (cfg_epoch == '0) ? '0 : cfg_epoch - 1'b1;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          if (!cfg_enable)            state     <= ST_IDLE;
          else if (epoch_cnt == '0)   state     <= ST_REFILL;
          else                        epoch_cnt <= epoch_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase

      if (cfg_we && cfg_idx_ok) quota[cfg_idx] <= cfg_quota;
    end
  end

`ifdef VAI_TX_SCHED_STATS_EN
  logic [31:0] xfer_cnt [NUM_SUB_AFUS];
  logic        stat_idx_ok;

  if ((2 ** SRC_W) == NUM_SUB_AFUS) begin : g_stat_full
    assign stat_idx_ok = 1'b1;
  end else begin : g_stat_part
    assign stat_idx_ok = (stat_idx < SRC_W'(NUM_SUB_AFUS));
  end

  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      stat_cnt <= '0;
      for (int unsigned i = 0; i < NUM_SUB_AFUS; i++) xfer_cnt[i] <= '0;
    end else begin
      if (grant_any && xfer_cnt[grant_idx] != '1)
        xfer_cnt[grant_idx] <= xfer_cnt[grant_idx] + 1'b1;
      stat_cnt <= stat_idx_ok ? xfer_cnt[stat_idx] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_vai_tx_sched.sv
// Scoreboard bench for vai_tx_sched: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_vai_tx_sched;
  import vai_sched_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int EW = 16;
  localparam int QW = 8;

  localparam int M_IDLE   = 0;
  localparam int M_REFILL = 1;
  localparam int M_RUN    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [7:0]  cfg_quota = '0;
  logic [15:0] cfg_epoch = '0;
  logic        cfg_enable = 1'b0;
`ifdef VAI_TX_SCHED_STATS_EN
  logic [1:0]  stat_idx = '0;
  logic [31:0] stat_cnt;
`endif

  always #5 clk = ~clk;

  vai_tx_sched_if #(.NUM_SUB_AFUS(N), .DW(DW)) bus ();

  vai_tx_sched #(
    .NUM_SUB_AFUS(N),
    .DW          (DW),
    .EPOCH_W     (EW),
    .QUOTA_W     (QW)
  ) dut (
    .pClk       (clk),
    .SoftReset_n(rst_n),
    .bus        (bus.slave),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_quota  (cfg_quota),
    .cfg_epoch  (cfg_epoch),
    .cfg_enable (cfg_enable)
`ifdef VAI_TX_SCHED_STATS_EN
    ,
    .stat_idx   (stat_idx),
    .stat_cnt   (stat_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            src;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural reference state
  int m_state;
  int m_ptr;
  int m_left;
  int m_tok[N];
  int m_quo[N];

  int dut_grant;
  int dut_xfers[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_ptr   = 0;
    m_left  = 0;
    for (int i = 0; i < N; i++) begin
      m_tok[i] = 0;
      m_quo[i] = int'(QUOTA_UNLIMITED);
    end
    exp_q.delete();
  endtask

  function automatic int model_pick();
    int j;
    if (m_state != M_RUN || bus.out_almfull) return -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (bus.req_valid[j] && (m_tok[j] > 0 || m_quo[j] == int'(QUOTA_UNLIMITED))) return j;
    end
    return -1;
  endfunction

  task automatic model_edge(input int g);
    exp_t e;
    if (g >= 0) begin
      e.data = bus.req_data[g];
      e.src  = g;
      exp_q.push_back(e);
      if (m_quo[g] != int'(QUOTA_UNLIMITED)) m_tok[g]--;
      m_ptr = (g + 1) % N;
    end
    case (m_state)
      M_IDLE:   if (cfg_enable) m_state = M_REFILL;
      M_REFILL: begin
        for (int i = 0; i < N; i++) m_tok[i] = m_quo[i];
        m_left  = (cfg_epoch == 0) ? 1 : int'(cfg_epoch);
        m_state = M_RUN;
      end
      default: begin
        if (!cfg_enable) m_state = M_IDLE;
        else begin
          m_left--;
          if (m_left == 0) m_state = M_REFILL;
        end
      end
    endcase
    if (cfg_we) m_quo[cfg_idx] = int'(cfg_quota);
  endtask

  // Called just after a falling edge with inputs settled; returns at the next falling edge.
  task automatic tick();
    int          g;
    logic [N-1:0] exp_rdy;
    #1;
    g = model_pick();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    dut_grant = -1;
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] & bus.req_ready[i]) begin
        dut_xfers[i]++;
        dut_grant = i;
      end
    end
    model_edge(g);
    @(negedge clk);
  endtask

  task automatic set_data();
    for (int i = 0; i < N; i++) bus.req_data[i] = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) check("out_valid_unexpected", 64'(bus.out_valid), 64'd0);
      else begin
        e = exp_q.pop_front();
        check("out_data", 64'(bus.out_data), 64'(e.data));
        check("out_src",  64'(bus.out_src),  64'(e.src));
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("out_valid_missing", 64'(bus.out_valid), 64'd1);
    end
  end

  initial begin
    int g_seq[$];
    int cyc;
    int cnt;
    int g0;
    int qv[N];

    bus.req_valid   = '0;
    bus.out_almfull = 1'b0;
    set_data();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_src",   64'(bus.out_src),   64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b1;

    // Scenario 1: unlimited quotas, everyone requesting
    cfg_epoch = 16'd100;
    bus.req_valid = '1;
    cfg_enable = 1'b1;
    cyc = 0;
    while (g_seq.size() < 5 && cyc < 20) begin
      set_data();
      tick();
      if (dut_grant >= 0) g_seq.push_back(dut_grant);
      cyc++;
    end
    check("s1_grant_count", 64'(g_seq.size()), 64'd5);
    foreach (g_seq[k]) check("s1_grant_order", 64'(g_seq[k]), 64'(k % N));

    // Scenario 3: backpressure window leaves the pointer alone
    repeat (3) begin set_data(); tick(); end
    g0 = dut_grant;
    bus.out_almfull = 1'b1;
    cnt = 0;
    repeat (5) begin
      set_data();
      tick();
      if (dut_grant >= 0) cnt++;
    end
    check("s3_xfers_in_almfull", 64'(cnt), 64'd0);
    bus.out_almfull = 1'b0;
    set_data();
    tick();
    check("s3_resume_grant", 64'(dut_grant), 64'((g0 + 1) % N));

    // Scenario 4: pointer parked at 3, only AFU2 requests after re-enable
    do_reset();
    bus.req_valid = '1;
    cfg_enable = 1'b1;
    cyc = 0;
    dut_grant = -1;
    while (dut_grant != 2 && cyc < 12) begin set_data(); tick(); cyc++; end
    check("s4_reach_grant2", 64'(dut_grant), 64'd2);
    bus.req_valid = '0;
    cfg_enable = 1'b0;
    tick();
    bus.req_valid = 4'b0100;
    cfg_enable = 1'b1;
    tick();
    tick();
    set_data();
    tick();
    check("s4_wrap_grant", 64'(dut_grant), 64'd2);

    // Scenario 2: quotas {2,1,0,3}, epoch of 20 cycles
    do_reset();
    cfg_enable = 1'b0;
    bus.req_valid = '0;
    qv = '{2, 1, 0, 3};
    for (int i = 0; i < N; i++) begin
      cfg_we = 1'b1;
      cfg_idx = 2'(i);
      cfg_quota = 8'(qv[i]);
      tick();
    end
    cfg_we = 1'b0;
    cfg_epoch = 16'd20;
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) dut_xfers[i] = 0;
    cfg_enable = 1'b1;
    cnt = 0;
    for (int t = 1; t <= 43; t++) begin
      set_data();
      tick();
      if (dut_grant >= 0 && ((t > 8 && t <= 23) || t > 29)) cnt++;
    end
    for (int i = 0; i < N; i++) check("s2_epoch_xfers", 64'(dut_xfers[i]), 64'(2 * qv[i]));
    check("s2_late_grants", 64'(cnt), 64'd0);

    // Scenario 5: asynchronous reset between edges while a transfer is in flight
    do_reset();
    cfg_epoch = 16'd100;
    bus.req_valid = '1;
    cfg_enable = 1'b1;
    repeat (5) begin set_data(); tick(); end
    #3;
    rst_n = 1'b0;
    #1;
    check("s5_out_valid", 64'(bus.out_valid), 64'd0);
    check("s5_out_data",  64'(bus.out_data),  64'd0);
    check("s5_out_src",   64'(bus.out_src),   64'd0);
    check("s5_req_ready", 64'(bus.req_ready), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    dut_grant = -1;
    while (dut_grant < 0 && cyc < 10) begin set_data(); tick(); cyc++; end
    check("s5_first_grant_tick", 64'(cyc), 64'd3);

`ifdef VAI_TX_SCHED_STATS_EN
    // Scenario 6: statistics readback for AFU1
    do_reset();
    bus.req_valid = 4'b0010;
    cfg_enable = 1'b1;
    cnt = 0;
    cyc = 0;
    while (cnt < 7 && cyc < 40) begin
      set_data();
      tick();
      if (dut_grant == 1) cnt++;
      cyc++;
    end
    check("s6_xfers", 64'(cnt), 64'd7);
    bus.req_valid = '0;
    stat_idx = 2'd1;
    tick();
    check("s6_stat_cnt", 64'(stat_cnt), 64'd7);
`endif

    // Randomized traffic with live reconfiguration
    do_reset();
    cfg_epoch = 16'd6;
    cfg_enable = 1'b1;
    repeat (600) begin
      bus.req_valid   = 4'($urandom);
      bus.out_almfull = ($urandom_range(0, 4) == 0);
      cfg_we          = ($urandom_range(0, 7) == 0);
      cfg_idx         = 2'($urandom);
      case ($urandom_range(0, 4))
        0:       cfg_quota = 8'd0;
        1:       cfg_quota = 8'd1;
        2:       cfg_quota = 8'd2;
        3:       cfg_quota = 8'd3;
        default: cfg_quota = QUOTA_UNLIMITED;
      endcase
      if ($urandom_range(0, 19) == 0) cfg_epoch = 16'($urandom_range(0, 10));
      if ($urandom_range(0, 29) == 0) cfg_enable = ~cfg_enable;
      set_data();
      tick();
    end

    cfg_we = 1'b0;
    bus.req_valid = '0;
    tick();
    tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
